card_shoe: RTL and testbench
============================

# card_shoe

Card source for the blackjack datapath. Sits between the free-running 1–10 rank counter and the round state machine. On a draw request it samples the counter's current rank and deals a card from a finite 52-card shoe, skipping ranks already exhausted. It reports remaining card count and an empty flag.

## Interface

Parameters:
- none; deck composition is fixed: ranks 1–9 four each, rank 10 sixteen each, 52 total.

Ports:
- clock  in  1  system clock, CLOCK_50 domain
- reset_n  in  1  asynchronous, active-low reset
- rand_in  in  4  current rank from the 1–10 counter
- draw  in  1  single-cycle draw strobe, active-high
- refill  in  1  synchronous shoe refill, active-high
- card  out  4  dealt rank, 1–10; holds its value until the next deal
- card_valid  out  1  one-cycle pulse when `card` is updated
- busy  out  1  a draw is being processed
- empty  out  1  shoe holds zero cards
- cards_left  out  6  cards remaining, 0–52

## Operation

- Storage:
  - Per-rank counters: ranks 1–9 are 3 bits (0–4); rank 10 is 5 bits (0–16).
  - `cards_left` equals the sum of all per-rank counters at all times.
- States:
  - IDLE: `busy`=0. If `draw`=1 and `empty`=0, latch the rank and go to SEARCH.
  - SEARCH: `busy`=1. If count[rank] != 0:
    - decrement count[rank] and `cards_left`;
    - set `card` to rank and `card_valid` to 1;
    - go to IDLE.
  - SEARCH with count[rank] = 0: advance rank (10 wraps to 1) and stay in SEARCH.
- Rank latch sanitising: `rand_in`=0 maps to 1; `rand_in` > 10 maps to 10.
- SEARCH always terminates within 10 cycles, because entry requires `empty`=0.
- `draw` is ignored in SEARCH; it is not queued.
- `draw` is ignored when `empty`=1; no `card_valid` is produced.
- `empty` = (`cards_left` == 0). It is registered and updates in the same cycle as the final decrement.
- `refill` has the highest priority among synchronous events:
  - restores all counters to full and sets `cards_left`=52 and `empty`=0;
  - forces IDLE;
  - aborts any search in progress, with no `card_valid` and no decrement.
- `refill` and `draw` in the same cycle: the refill wins and the draw is dropped.
- Reset values:
  - state IDLE; all counters full; `cards_left`=52;
  - `card`=0, `card_valid`=0, `busy`=0, `empty`=0.
- Reset mid-search returns immediately to the reset values. No card is dealt.

## Timing

- All state changes occur on the rising edge of `clock`, except the asynchronous reset.
- `draw` sampled high at edge N in IDLE: `busy`=1 after edge N.
- Deal latency: with k exhausted ranks skipped, `card_valid`=1 after edge N+1+k.
  - `card_valid` lasts exactly one cycle.
  - `busy` returns to 0 in the same cycle `card_valid` is high.
- Minimum spacing between accepted draws is 2 cycles: a new `draw` is accepted in the `card_valid` cycle.
- `card`, `cards_left` and `empty` update together in the `card_valid` cycle.

## Configuration

- `CARD_SHOE_DEPLETION_EN` defined, finite shoe: behaviour as described above.
- `CARD_SHOE_DEPLETION_EN` undefined, infinite shoe:
  - no per-rank counters;
  - SEARCH always hits, so latency is fixed at 1 cycle;
  - `cards_left` is held at 52 and `empty` is held at 0;
  - `refill` only aborts and returns to IDLE.

## Test plan

- Reset with `reset_n`=0 → `cards_left`=52, `empty`=0, `card`=0, `card_valid`=0, `busy`=0.
- `rand_in`=7, one `draw` pulse → after 2 edges, `card`=7 with a one-cycle `card_valid`, then `cards_left`=51.
- Four draws with `rand_in`=3, then a fifth with `rand_in`=3 → the fifth deals `card`=4 with latency 2 and `cards_left`=47. With rank 10 exhausted, `rand_in`=10 → `card`=1.
- Draw 52 cards → `empty`=1 and `cards_left`=0 in the 52nd `card_valid` cycle. A 53rd `draw` gives no `card_valid` and `busy` stays 0.
- Exhaust ranks 4–9 and 10, then `draw` with `rand_in`=4. Assert `refill` during SEARCH → no `card_valid`, `cards_left`=52, state IDLE. Repeat with `reset_n` pulsed low mid-SEARCH → reset values.
- Build without `CARD_SHOE_DEPLETION_EN`, then five draws with `rand_in`=3 → five deals with `card`=3, each at latency 1, and `cards_left` stays 52.

Source files
------------

// File: rtl/card_shoe.sv
// card_shoe: card source for the blackjack datapath.
// On a draw request the current rank from the free-running 1-10 counter is
// latched and a card of that rank is dealt; exhausted ranks are skipped by
// walking upward (10 wraps to 1) one rank per cycle.
// Build option CARD_SHOE_DEPLETION_EN:
//   defined   -> finite 52-card shoe with per-rank counters
//   undefined -> infinite shoe; every search hits at once, cards_left stays 52
module card_shoe (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] rand_in,
  input  logic       draw,
  input  logic       refill,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic       empty,
  output logic [5:0] cards_left
);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  state_t     state, state_next;
  logic [3:0] rank, rank_next;
  logic       hit;
  logic       deal;

  // Clamp the counter value into the legal 1..10 range.
  function automatic logic [3:0] sanitize(input logic [3:0] r);
    if (r == 4'd0)       return 4'd1;
    else if (r > 4'd10)  return 4'd10;
    else                 return r;
  endfunction

  // Next rank to probe when the current one is exhausted.
  function automatic logic [3:0] advance(input logic [3:0] r);
    return (r == 4'd10) ? 4'd1 : r + 4'd1;
  endfunction

  assign busy = (state == SEARCH);

`ifdef CARD_SHOE_DEPLETION_EN
  logic [2:0] count_low [1:9];  // ranks 1..9, 0..4 each
  logic [4:0] count_ten;        // rank 10, 0..16

  // Does the shoe still hold a card of the rank being probed?
  always_comb begin
    if (rank == 4'd10) hit = (count_ten != 5'd0);
    else               hit = (count_low[rank] != 3'd0);
  end

  // Per-rank counters, total and empty flag; refill beats any deal.
  // NOTE: the counter array is reset along with everything else because the
  // shoe must be full straight out of reset; it is a handful of flops, not RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i <= 9; i++) count_low[i] <= 3'd4;
      count_ten  <= 5'd16;
      cards_left <= 6'd52;
      empty      <= 1'b0;
    end else if (refill) begin
      for (int i = 1; i <= 9; i++) count_low[i] <= 3'd4;
      count_ten  <= 5'd16;
      cards_left <= 6'd52;
      empty      <= 1'b0;
    end else if (deal) begin
      if (rank == 4'd10) count_ten       <= count_ten - 5'd1;
      else               count_low[rank] <= count_low[rank] - 3'd1;
      cards_left <= cards_left - 6'd1;
      empty      <= (cards_left == 6'd1);
    end
  end
`else
  // Infinite shoe: every rank is always available.
  assign hit        = 1'b1;
  assign cards_left = 6'd52;
  assign empty      = 1'b0;
`endif

  // State, latched rank and dealt-card registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rank       <= 4'd1;
      card       <= 4'd0;
      card_valid <= 1'b0;
    end else begin
      state      <= state_next;
      rank       <= rank_next;
      card_valid <= deal;
      if (deal) card <= rank;
    end
  end

  // Next-state logic: accept draws in IDLE, walk ranks in SEARCH.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and a latch is never inferred.
    state_next = state;
    rank_next  = rank;
    deal       = 1'b0;
    if (refill) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (draw && !empty) begin
            rank_next  = sanitize(rand_in);
            state_next = SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            deal       = 1'b1;
            state_next = IDLE;
          end else begin
            rank_next = advance(rank);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe. Stimulus pushes the expected deal (card,
// cards_left, empty, cycle it must appear in); a monitor pops and compares
// on every card_valid. The finite-shoe sequence is used when
// CARD_SHOE_DEPLETION_EN is defined, the infinite-shoe one otherwise.
module tb_card_shoe;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] rand_in;
  logic       draw;
  logic       refill;
  logic [3:0] card;
  logic       card_valid;
  logic       busy;
  logic       empty;
  logic [5:0] cards_left;

  typedef struct {
    int card;
    int left;
    int empty;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   mcount [1:10];
  int   mleft;

  card_shoe dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rand_in    (rand_in),
    .draw       (draw),
    .refill     (refill),
    .card       (card),
    .card_valid (card_valid),
    .busy       (busy),
    .empty      (empty),
    .cards_left (cards_left)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every card_valid must match the oldest expected deal.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && card_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_card_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("deal_card", card, e.card);
        check("deal_cards_left", cards_left, e.left);
        check("deal_empty", empty, e.empty);
        check("deal_cycle", cycle, e.due);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Pulse draw with rank r; k ranks skipped. Returns in the card_valid cycle.
  task automatic do_draw(input logic [3:0] r, input int exp_card, input int k,
                         input int exp_left, input int exp_empty);
    exp_t e;
    e.card  = exp_card;
    e.left  = exp_left;
    e.empty = exp_empty;
    e.due   = cycle + 2 + k;
    sb.push_back(e);
    rand_in = r;
    draw    = 1'b1;
    @(posedge clock); #1;
    draw = 1'b0;
    check("busy_after_draw", busy, 1);
    repeat (k + 1) begin @(posedge clock); #1; end
    check("busy_low_on_valid", busy, 0);
  endtask

  task automatic model_full();
    for (int i = 1; i <= 9; i++) mcount[i] = 4;
    mcount[10] = 16;
    mleft = 52;
  endtask

  // Finite-shoe reference: sanitise, skip exhausted ranks, decrement.
  task automatic draw_m(input logic [3:0] r);
    int s, k;
    s = (r == 0) ? 1 : (r > 10) ? 10 : int'(r);
    k = 0;
    while (mcount[s] == 0) begin
      s = (s == 10) ? 1 : s + 1;
      k++;
    end
    mcount[s]--;
    mleft--;
    do_draw(r, s, k, mleft, (mleft == 0) ? 1 : 0);
  endtask

  task automatic pulse_refill();
    refill = 1'b1;
    @(posedge clock); #1;
    refill = 1'b0;
    model_full();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    reset_n = 1'b0;
    rand_in = 4'd0;
    draw    = 1'b0;
    refill  = 1'b0;
    model_full();
    idle(2);
    check("reset_cards_left", cards_left, 52);
    check("reset_empty", empty, 0);
    check("reset_card", card, 0);
    check("reset_card_valid", card_valid, 0);
    check("reset_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

`ifdef CARD_SHOE_DEPLETION_EN
    // First deal from a full shoe.
    draw_m(4'd7);                                  // card 7, left 51
    pulse_refill();
    check("refill_cards_left", cards_left, 52);
    // Exhaust rank 3; the fifth draw skips to 4 with latency 2, left 47.
    for (int i = 0; i < 4; i++) draw_m(4'd3);
    do_draw(4'd3, 4, 1, 47, 0);
    mcount[4]--; mleft--;
    // Exhaust rank 10; drawing 10 wraps to rank 1.
    for (int i = 0; i < 16; i++) draw_m(4'd10);
    do_draw(4'd10, 1, 1, 30, 0);
    mcount[1]--; mleft--;
    // Drain the whole shoe.
    pulse_refill();
    for (int i = 0; i < 52; i++) draw_m(4'((i % 10) + 1));
    check("drained_empty", empty, 1);
    check("drained_cards_left", cards_left, 0);
    // Draw on an empty shoe is ignored.
    idle(1);
    rand_in = 4'd5;
    draw    = 1'b1;
    idle(1);
    draw = 1'b0;
    check("empty_draw_busy", busy, 0);
    idle(3);
    check("empty_draw_no_valid", card_valid, 0);
    // Refill aborts a long search.
    pulse_refill();
    for (int r = 4; r <= 9; r++) for (int i = 0; i < 4; i++) draw_m(4'(r));
    for (int i = 0; i < 16; i++) draw_m(4'd10);
    idle(1);
    rand_in = 4'd4;
    draw    = 1'b1;
    idle(1);
    draw = 1'b0;
    check("long_search_busy", busy, 1);
    idle(3);
    pulse_refill();
    check("abort_busy", busy, 0);
    check("abort_valid", card_valid, 0);
    check("abort_cards_left", cards_left, 52);
    check("abort_empty", empty, 0);
    idle(3);
    // Reset mid-search.
    for (int r = 4; r <= 9; r++) for (int i = 0; i < 4; i++) draw_m(4'(r));
    for (int i = 0; i < 16; i++) draw_m(4'd10);
    idle(1);
    rand_in = 4'd4;
    draw    = 1'b1;
    idle(1);
    draw = 1'b0;
    idle(2);
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_card", card, 0);
    check("midreset_valid", card_valid, 0);
    check("midreset_cards_left", cards_left, 52);
    check("midreset_empty", empty, 0);
    model_full();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    draw_m(4'd7);
`else
    // Infinite shoe: every deal has latency 1 and cards_left stays 52.
    do_draw(4'd7, 7, 0, 52, 0);
    for (int i = 0; i < 5; i++) do_draw(4'd3, 3, 0, 52, 0);
    // Rank sanitising.
    do_draw(4'd0, 1, 0, 52, 0);
    do_draw(4'd15, 10, 0, 52, 0);
    do_draw(4'd11, 10, 0, 52, 0);
    do_draw(4'd10, 10, 0, 52, 0);
    // Draw held into SEARCH is not queued: exactly one deal.
    begin
      exp_t e;
      e.card = 5; e.left = 52; e.empty = 0; e.due = cycle + 2;
      sb.push_back(e);
    end
    rand_in = 4'd5;
    draw    = 1'b1;
    idle(1);
    check("held_draw_busy", busy, 1);
    rand_in = 4'd8;
    idle(1);
    draw = 1'b0;
    idle(3);
    check("held_draw_card", card, 5);
    // Refill and draw together: the draw is dropped.
    rand_in = 4'd6;
    draw    = 1'b1;
    refill  = 1'b1;
    idle(1);
    draw   = 1'b0;
    refill = 1'b0;
    check("refill_draw_busy", busy, 0);
    idle(3);
    check("refill_draw_card", card, 5);
    // Refill during SEARCH aborts the deal.
    rand_in = 4'd6;
    draw    = 1'b1;
    idle(1);
    draw = 1'b0;
    check("search_busy", busy, 1);
    refill = 1'b1;
    idle(1);
    refill = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", card_valid, 0);
    check("abort_cards_left", cards_left, 52);
    idle(2);
    check("abort_card_held", card, 5);
    // Reset during SEARCH returns to reset values at once.
    rand_in = 4'd2;
    draw    = 1'b1;
    idle(1);
    draw = 1'b0;
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_card", card, 0);
    check("midreset_valid", card_valid, 0);
    check("midreset_cards_left", cards_left, 52);
    check("midreset_empty", empty, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_draw(4'd9, 9, 0, 52, 0);
`endif

    // Every expected deal must have appeared.
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    check("scoreboard_drained", sb.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
